// File: rtl/font_scroll_pkg.sv
// Shared encodings for the font ROM scan sequencer.
package font_scroll_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP     = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_REVLOOP  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/scroll_step_div.sv
// Tick prescaler: emits one step pulse every speed+1 enabled ticks.
module scroll_step_div #(
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic          tick,
  input  logic [SW-1:0] speed,
  output logic          step
);

  logic [SW-1:0] div;

  assign step = en && tick && (div == speed);

  // clr has priority so a start in the same clk discards the tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (clr) begin
      div <= '0;
    end else if (en && tick) begin
      div <= step ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/font_scroll_ctrl.sv
// Steps the font ROM address through a programmable window at a tick-derived
// rate, in one of four scan modes, and registers the ROM data onto the LEDs.
module font_scroll_ctrl
  import font_scroll_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 10,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          start,
  input  logic          pause,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] first_adr,
  input  logic [AW-1:0] last_adr,
  input  logic [SW-1:0] speed,
  output logic [AW-1:0] rom_adr,
  input  logic [DW-1:0] rom_dat,
  output logic [DW-1:0] led,
  output logic          busy,
  output logic          done
);

  typedef struct packed {
    logic [AW-1:0] adr;
    dir_t          dir;
    logic          fin;
  } step_t;

  // Window bounds are sampled here, so config changes land on the next step.
  function automatic step_t next_step(input mode_t m, input dir_t d,
                                      input logic [AW-1:0] a,
                                      input logic [AW-1:0] f,
                                      input logic [AW-1:0] l);
    step_t r;
    r.adr = a;
    r.dir = d;
    r.fin = 1'b0;
    if (a < f || a > l) begin
      r.adr = (m == MODE_REVLOOP) ? l : f;
      r.dir = (m == MODE_REVLOOP) ? DIR_DOWN : DIR_UP;
    end else begin
      case (m)
        MODE_LOOP: r.adr = (a == l) ? f : a + 1'b1;
        MODE_ONESHOT: begin
          if (a == l) r.fin = 1'b1;
          else        r.adr = a + 1'b1;
        end
        MODE_PINGPONG: begin
          if (d == DIR_UP) begin
            if (a == l) begin
              r.dir = DIR_DOWN;
              if (f != l) r.adr = l - 1'b1;
            end else begin
              r.adr = a + 1'b1;
            end
          end else begin
            if (a == f) begin
              r.dir = DIR_UP;
              if (f != l) r.adr = f + 1'b1;
            end else begin
              r.adr = a - 1'b1;
            end
          end
        end
        default: r.adr = (a == f) ? l : a - 1'b1;
      endcase
    end
    return r;
  endfunction

  state_t state, state_n;
  dir_t   dir;
  step_t  nx;
  logic   start_ok, en, step, done_n;

  assign start_ok = start && (first_adr <= last_adr);
  assign en       = (state == ST_RUN) && !pause && !start_ok;
  assign busy     = (state == ST_RUN) || (state == ST_PAUSE);

  scroll_step_div #(.SW(SW)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (en),
    .tick  (tick),
    .speed (speed),
    .step  (step)
  );

  always_comb begin
    nx      = next_step(mode_t'(mode), dir, rom_adr, first_adr, last_adr);
    state_n = state;
    done_n  = 1'b0;
    if (start_ok) begin
      state_n = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state_n = ST_PAUSE;
          end else if (step && nx.fin) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end
        end
        ST_PAUSE: if (!pause) state_n = ST_RUN;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      rom_adr <= '0;
      dir     <= DIR_UP;
      led     <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
      led   <= (state != ST_IDLE) ? rom_dat : '0;
      if (start_ok) begin
        rom_adr <= (mode_t'(mode) == MODE_REVLOOP) ? last_adr : first_adr;
        dir     <= (mode_t'(mode) == MODE_REVLOOP) ? DIR_DOWN : DIR_UP;
      end else if (step) begin
        rom_adr <= nx.adr;
        dir     <= nx.dir;
      end
    end
  end

endmodule

// File: tb/tb_font_scroll_ctrl.sv
// Bench for font_scroll_ctrl: directed scan scenarios, then random stimulus
// against a behavioural model of the scan rules.
module tb_font_scroll_ctrl;

  localparam int AW = 5;
  localparam int DW = 10;
  localparam int SW = 3;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] first_adr = '0;
  logic [AW-1:0] last_adr = '0;
  logic [SW-1:0] speed = '0;
  logic [AW-1:0] rom_adr;
  logic [DW-1:0] rom_dat;
  logic [DW-1:0] led;
  logic          busy;
  logic          done;

  logic [DW-1:0] rom [32];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_st, m_adr, m_div, m_led;
  bit m_up, m_done;

  int seq1 [6] = '{1, 2, 3, 0, 1, 2};
  int seq2 [6] = '{27, 28, 28, 29, 29, 29};
  int seq3 [8] = '{5, 6, 5, 4, 5, 6, 5, 4};
  int seq4 [4] = '{17, 16, 18, 17};

  assign rom_dat = rom[rom_adr];

  font_scroll_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .pause     (pause),
    .mode      (mode),
    .first_adr (first_adr),
    .last_adr  (last_adr),
    .speed     (speed),
    .rom_adr   (rom_adr),
    .rom_dat   (rom_dat),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_adr = 0; m_div = 0; m_up = 1'b1; m_led = 0; m_done = 1'b0;
  endtask

  task automatic model_step();
    int f, l;
    f = int'(first_adr);
    l = int'(last_adr);
    if (m_adr < f || m_adr > l) begin
      m_adr = (mode == 2'd3) ? l : f;
      m_up  = (mode != 2'd3);
    end else if (mode == 2'd0) begin
      m_adr = (m_adr == l) ? f : m_adr + 1;
    end else if (mode == 2'd1) begin
      if (m_adr == l) begin m_st = S_DONE; m_done = 1'b1; end
      else m_adr = m_adr + 1;
    end else if (mode == 2'd2) begin
      if (m_up) begin
        if (m_adr == l) begin m_up = 1'b0; m_adr = (f == l) ? l : l - 1; end
        else m_adr = m_adr + 1;
      end else begin
        if (m_adr == f) begin m_up = 1'b1; m_adr = (f == l) ? f : f + 1; end
        else m_adr = m_adr - 1;
      end
    end else begin
      m_adr = (m_adr == f) ? l : m_adr - 1;
    end
  endtask

  // One clock of the scan rules, using the inputs present at the edge.
  task automatic model_edge();
    int nled;
    if (reset) begin
      model_reset();
      return;
    end
    nled   = (m_st != S_IDLE) ? int'(rom[m_adr]) : 0;
    m_done = 1'b0;
    if (start && first_adr <= last_adr) begin
      m_st  = S_RUN;
      m_div = 0;
      m_adr = (mode == 2'd3) ? int'(last_adr) : int'(first_adr);
      m_up  = (mode != 2'd3);
    end else if (m_st == S_RUN) begin
      if (pause) m_st = S_PAUSE;
      else if (tick) begin
        if (m_div == int'(speed)) begin
          m_div = 0;
          model_step();
        end else begin
          m_div = (m_div + 1) % 8;
        end
      end
    end else if (m_st == S_PAUSE && !pause) begin
      m_st = S_RUN;
    end
    m_led = nled;
  endtask

  task automatic check_all();
    check("rom_adr", 32'(rom_adr), m_adr);
    check("led", 32'(led), m_led);
    check("busy", 32'(busy), (m_st == S_RUN || m_st == S_PAUSE) ? 1 : 0);
    check("done", 32'(done), m_done ? 1 : 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic cfg(input int m, input int f, input int l, input int s);
    mode      = 2'(m);
    first_adr = AW'(f);
    last_adr  = AW'(l);
    speed     = SW'(s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = DW'($urandom_range(1, 1023));
    rom[1]  = 10'h382;
    rom[29] = 10'h044;
    model_reset();

    #1;
    do_reset();
    check("reset_led", 32'(led), 0);
    cyc();

    // LOOP 0..3, speed 0
    cfg(0, 0, 3, 0);
    pulse_start();
    check("loop_start", 32'(rom_adr), 0);
    tk();
    check("loop_adr0", 32'(rom_adr), 1);
    cyc();
    check("loop_led1", 32'(led), 32'h382);
    for (int i = 1; i < 6; i++) begin
      tk();
      check("loop_adr", 32'(rom_adr), seq1[i]);
    end

    // ONESHOT 1B..1D, speed 1
    cfg(1, 27, 29, 1);
    pulse_start();
    check("oneshot_start", 32'(rom_adr), 27);
    for (int i = 0; i < 6; i++) begin
      tk();
      check("oneshot_adr", 32'(rom_adr), seq2[i]);
    end
    check("oneshot_done", 32'(done), 1);
    cyc();
    check("oneshot_led", 32'(led), 32'h044);
    check("oneshot_busy", 32'(busy), 0);
    check("oneshot_done_clr", 32'(done), 0);
    for (int i = 0; i < 4; i++) tk();
    check("oneshot_hold_adr", 32'(rom_adr), 29);
    check("oneshot_hold_led", 32'(led), 32'h044);

    // PINGPONG 4..6, then degenerate window 9..9
    cfg(2, 4, 6, 0);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      tk();
      check("pp_adr", 32'(rom_adr), seq3[i]);
    end
    cfg(2, 9, 9, 0);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      tk();
      check("pp_single", 32'(rom_adr), 9);
    end

    // REVLOOP 10..12
    cfg(3, 16, 18, 0);
    pulse_start();
    check("rev_start", 32'(rom_adr), 18);
    for (int i = 0; i < 4; i++) begin
      tk();
      check("rev_adr", 32'(rom_adr), seq4[i]);
    end

    // Pause freezes address and frame
    cfg(0, 0, 7, 0);
    pulse_start();
    tk();
    tk();
    pause = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      tk();
      check("pause_adr", 32'(rom_adr), 2);
      check("pause_led", 32'(led), 32'(rom[2]));
    end
    pause = 1'b0;
    cyc();
    tk();
    check("resume_adr", 32'(rom_adr), 3);

    // start and tick together: start wins, divider restarts
    speed = SW'(1);
    start = 1'b1;
    tick  = 1'b1;
    cyc();
    start = 1'b0;
    tick  = 1'b0;
    check("start_tick_adr", 32'(rom_adr), 0);
    tk();
    check("start_tick_div", 32'(rom_adr), 0);
    tk();
    check("start_tick_step", 32'(rom_adr), 1);

    // Inverted window is ignored from IDLE
    do_reset();
    cfg(0, 5, 2, 0);
    pulse_start();
    tk();
    cyc();
    check("bad_win_busy", 32'(busy), 0);
    check("bad_win_led", 32'(led), 0);
    check("bad_win_adr", 32'(rom_adr), 0);

    // Reset in the middle of a run clears outputs at once
    cfg(0, 2, 5, 0);
    pulse_start();
    tk();
    tk();
    cyc();
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_reset_led", 32'(led), 0);
    check("mid_reset_adr", 32'(rom_adr), 0);
    check("mid_reset_busy", 32'(busy), 0);
    cyc();
    reset = 1'b0;
    cyc();

    // Random traffic including mid-run reconfiguration
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        int f, l;
        f = int'($urandom_range(0, 31));
        l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                        : int'($urandom_range(f, 31));
        cfg(int'($urandom_range(0, 3)), f, l, int'($urandom_range(0, 7)));
      end
      start = ($urandom_range(0, 39) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      if ($urandom_range(0, 1499) == 0) do_reset();
      else cyc();
    end
    start = 1'b0;
    tick  = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
